// File: rtl/hms_counter_pkg.sv
// rtl/hms_counter_pkg.sv - shared state, direction and default modulus definitions for hms_counter
package hms_counter_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam int DEF_SEC_MOD = 60;
  localparam int DEF_MIN_MOD = 60;
  localparam int DEF_HR_MOD  = 24;

endpackage

// File: rtl/mod_stage.sv
// rtl/mod_stage.sv - single modulo-MOD up/down stage with clear, saturating load and step
module mod_stage
  import hms_counter_pkg::*;
#(
  parameter int MOD = 60,
  parameter int W   = $clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         step,
  input  logic         dir,
  output logic [W-1:0] val,
  output logic         at_term
);

  localparam logic [W-1:0] MAX = W'(MOD - 1);

  logic [W-1:0] ld_sat;

  // Field width can hold values beyond MOD-1; clamp rather than wrap.
  assign ld_sat  = (ld_val > MAX) ? MAX : ld_val;
  assign at_term = (dir == DIR_DN) ? (val == '0) : (val == MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (ld) begin
      val <= ld_sat;
    end else if (step) begin
      if (dir == DIR_DN) begin
        val <= (val == '0) ? MAX : val - W'(1);
      end else begin
        val <= (val == MAX) ? '0 : val + W'(1);
      end
    end
  end

endmodule

// File: rtl/hms_counter.sv
// rtl/hms_counter.sv - cascaded hours/minutes/seconds counter with up/down, load and one-shot halt
module hms_counter
  import hms_counter_pkg::*;
#(
  parameter int SEC_MOD = DEF_SEC_MOD,
  parameter int MIN_MOD = DEF_MIN_MOD,
  parameter int HR_MOD  = DEF_HR_MOD,
  localparam int SEC_W  = $clog2(SEC_MOD),
  localparam int MIN_W  = $clog2(MIN_MOD),
  localparam int HR_W   = $clog2(HR_MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic [MIN_W-1:0] load_min,
  input  logic [HR_W-1:0]  load_hr,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic             sec_carry,
  output logic             min_carry,
  output logic             wrap,
  output logic             done
);

  localparam logic [SEC_W-1:0] SEC_PRE_UP = SEC_W'(SEC_MOD - 2);
  localparam logic [SEC_W-1:0] SEC_PRE_DN = SEC_W'(1);

  state_t state, state_nxt;
  logic   done_nxt;
  logic   step_act;
  logic   sec_term, min_term, hr_term;
  logic   sec_pre;
  logic   arrive;

  assign step_act  = enable && (state == ST_RUN);
  assign sec_carry = step_act && sec_term;
  assign min_carry = sec_carry && min_term;
  assign wrap      = min_carry && hr_term && !oneshot;

  // Seconds always move on a step, so the counter can only land on its terminal
  // when seconds sit one short of terminal while minutes and hours already are there.
  assign sec_pre = (dir == DIR_DN) ? (sec == SEC_PRE_DN) : (sec == SEC_PRE_UP);
  assign arrive  = step_act && sec_pre && min_term && hr_term;

  mod_stage #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk(clk), .rst_n(rst_n), .clr(clear), .ld(load), .ld_val(load_sec),
    .step(step_act), .dir(dir), .val(sec), .at_term(sec_term)
  );

  mod_stage #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk(clk), .rst_n(rst_n), .clr(clear), .ld(load), .ld_val(load_min),
    .step(sec_carry), .dir(dir), .val(min), .at_term(min_term)
  );

  mod_stage #(.MOD(HR_MOD), .W(HR_W)) u_hr (
    .clk(clk), .rst_n(rst_n), .clr(clear), .ld(load), .ld_val(load_hr),
    .step(min_carry), .dir(dir), .val(hr), .at_term(hr_term)
  );

  always_comb begin
    state_nxt = state;
    done_nxt  = done;
    if (clear || load) begin
      state_nxt = ST_RUN;
      done_nxt  = 1'b0;
    end else if (arrive && oneshot) begin
      state_nxt = ST_HALT;
      done_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

endmodule
